// File: rtl/digit_serial_adder.sv
// ============================================================================
// digit_serial_adder
// ----------------------------------------------------------------------------
// Multi-cycle adder. It adds two WIDTH-bit operands DIGIT bits per clock using
// a small ripple-carry digit slice. The carry between digits is held in a
// register. Operands arrive through a valid/ready handshake, and the result
// (sum, carry-out, signed overflow) leaves through another one. Use it for wide
// additions where area matters more than latency.
//
// Parameters
//   WIDTH      operand / sum width in bits (multiple of DIGIT)
//   DIGIT      bits added per clock, 1..WIDTH; N = WIDTH/DIGIT digit cycles
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands present
//   in_ready   block can accept operands (high exactly in IDLE)
//   a, b       operands
//   ci         carry-in
//   sub        subtract select (only with DIGIT_SERIAL_ADDER_SUB_EN)
//   out_valid  result present (high exactly in DONE)
//   out_ready  consumer accepts the result
//   s          sum, registered
//   co         carry out of bit WIDTH-1, registered
//   ovf        signed two's-complement overflow, registered
//
// Configuration macro
//   DIGIT_SERIAL_ADDER_SUB_EN  adds the sub port. When sub=1, b is inverted
//                              and the carry-in is forced to 1.
// ============================================================================
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             a_msb;
    logic             b_msb;

    logic [WIDTH-1:0] b_cap;
    logic             c_cap;
    logic [DIGIT:0]   digit_sum;
    logic [DIGIT-1:0] d;
    logic             c;
    logic             last;
    logic [WIDTH-1:0] s_next;

    // These are the operand B and the carry-in as they are loaded at acceptance.
    // In subtract mode, a - b is computed as a + ~b + 1, so ci plays no part.
    always_comb begin
        b_cap = b;
        c_cap = ci;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_cap = ~b;
            c_cap = 1'b1;
        end
`endif
    end

    // The digit slice adds the low digit of each operand register plus the carry.
    // The carry ripples only within this DIGIT+1-bit add.
    assign digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};
    assign d    = digit_sum[DIGIT-1:0];
    assign c    = digit_sum[DIGIT];
    assign last = (cnt == CW'(N - 1));

    // Each digit result enters the sum from the MSB side. After N digits the
    // first digit therefore sits in the lowest position. With a single digit
    // cycle there is nothing to shift, and the digit is the whole sum.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign s_next = d;
        end else begin : g_multi_digit
            assign s_next = {d, s[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Control FSM and datapath registers. in_ready and out_valid are registered
    // together with the state, so each one always matches its state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b_cap;
                        carry    <= c_cap;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b_cap[WIDTH-1];
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    s     <= s_next;
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= c;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // The top digit of the sum holds the result MSB.
                        co        <= c;
                        ovf       <= (a_msb ~^ b_msb) & (a_msb ^ d[DIGIT-1]);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, multi-cycle successor to the team's 4-bit ripple-carry adder. It adds two WIDTH-bit operands DIGIT bits per clock with a small ripple-carry digit slice, and carries the carry between digits in a register. It sits between producer and consumer stages through valid/ready handshakes and reports the sum, carry-out and signed overflow. Its purpose is wide additions where area matters more than latency.

## Interface
- WIDTH, 16: operand and sum width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits added per clock, 1..WIDTH. N = WIDTH/DIGIT is the number of digit cycles.
- clk  in  1  the single clock. All logic changes on its rising edge.
- rst  in  1  reset. Synchronous and active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands. Equals 1 exactly when the state is IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in.
- sub  in  1  subtract select. This port exists only with DIGIT_SERIAL_ADDER_SUB_EN.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  sum, registered.
- co  out  1  carry out of bit WIDTH-1, registered.
- ovf  out  1  signed two's-complement overflow, registered.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: digit cycles, counted by a digit counter.
  - DONE: out_valid=1.
- Reset (rst=1 at an edge), from any state:
  - State goes to IDLE and the counter clears.
  - s=0, co=0, ovf=0, out_valid=0, in_ready=1.
  - Any in-flight operation is discarded without a result.
- IDLE to RUN:
  - Fires when in_valid and in_ready are both 1 at an edge.
  - Captures a and b into shift registers and ci into the carry register.
  - Clears the counter.
- RUN, one edge per digit i = 0..N-1:
  - The digit sum is {c, d} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry. Widths are DIGIT+1 bits, unsigned.
  - d is shifted into s from the MSB side. The operand registers shift right by DIGIT. carry <= c.
  - On the final digit: co <= c, ovf <= (a_msb ~^ b_msb) & (a_msb ^ d_msb), and state goes to DONE. a_msb and b_msb are the captured operand MSBs after any inversion.
- DONE:
  - s, co and ovf are held stable while out_ready=0.
  - When out_valid and out_ready are both 1 at an edge, state goes to IDLE.
  - out_valid drops and s, co and ovf keep their values.
- in_valid is ignored outside IDLE. In particular, an in_valid/out_ready overlap in DONE does not accept new operands.
- Carry chain: the carry ripples inside a digit. Between digits it passes only through the carry register.

## Timing
- Latency: acceptance at edge k. Digits are processed at edges k+1..k+N. out_valid is 1 from edge k+N.
- Minimum spacing between acceptances is N+2 edges: 1 accept edge, N digit edges, 1 output-handshake edge.
- DIGIT=WIDTH (N=1): a single RUN edge. Behaviour is otherwise identical.
- out_ready held 0 in DONE: the block stalls indefinitely. No state or output changes.
- rst=1 together with in_valid=1 in IDLE: reset wins and nothing is captured.

## Configuration
- DIGIT_SERIAL_ADDER_SUB_EN defined:
  - The sub port exists and is sampled at acceptance.
  - When sub=1, b is captured inverted, the initial carry is forced to 1, and ci is ignored.
  - co=1 then means no borrow. ovf uses the inverted b MSB.
- DIGIT_SERIAL_ADDER_SUB_EN undefined: there is no sub port and the block only adds.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 (N=4).
1. Reset, then a=0x000B, b=0x0004, ci=0 accepted at edge k -> out_valid first 1 at edge k+4; s=0x000F, co=0, ovf=0.
2. a=0xFFFF, b=0xFFFD, ci=1 -> s=0xFFFD, co=1, ovf=0. This exercises carry propagation across all digits.
3. a=0x7FFF, b=0x0001, ci=0 -> s=0x8000, co=0, ovf=1. Also a=0x8000, b=0x8000 -> s=0x0000, co=1, ovf=1.
4. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and a new a/b -> s, co and ovf stay stable and in_ready=0. The edge where out_ready=1 -> IDLE. The new operands are accepted only on a following edge.
5. rst pulsed for one edge after 2 RUN edges -> next cycle in_ready=1, out_valid=0, s=0. Then a=0x1234, b=0x1111 -> s=0x2345, co=0.
6. With DIGIT_SERIAL_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, co=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
